// File: rtl/button_dir_ctrl.sv
// button_dir_ctrl: synchronizes and debounces the direction button and toggles dir on each press; LONG_PRESS_EN adds a long-hold pulse
module button_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic        DIR_RESET       = 1'b1,
  parameter int unsigned LONG_CYCLES     = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic dir,
  output logic long_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
  state_t state_q, state_d;
  logic s0_q, s1_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d, dir_q, dir_d, fsm_dir;
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    fsm_dir   = dir_q;
    case (state_q)
      IDLE_LOW: if (s1_q) begin
        state_d = WAIT_HIGH;
        cnt_d   = CW'(1);
      end
      WAIT_HIGH: if (!s1_q) state_d = IDLE_LOW;
      else if (cnt_q == CNT_LAST) begin
        state_d = IDLE_HIGH;
        level_d = 1'b1;
        press_d = 1'b1;
        fsm_dir = ~dir_q;
      end else cnt_d = cnt_q + 1'b1;
      IDLE_HIGH: if (!s1_q) begin
        state_d = WAIT_LOW;
        cnt_d   = CW'(1);
      end
      WAIT_LOW: if (s1_q) state_d = IDLE_HIGH;
      else if (cnt_q == CNT_LAST) begin
        state_d   = IDLE_LOW;
        level_d   = 1'b0;
        release_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE_LOW;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      dir_q     <= DIR_RESET;
    end else begin
      s0_q      <= btn_in;
      s1_q      <= s0_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      dir_q     <= dir_d;
    end
  end
`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  logic [HW-1:0] hold_q, hold_d;
  logic long_q, long_d, held;
  // a release bounce back to IDLE_HIGH keeps counting; hold clears only while the button is released
  assign held = (state_q == IDLE_HIGH) || (state_q == WAIT_LOW);
  always_comb begin
    long_d = held && (hold_q == HOLD_LAST);
    hold_d = !held ? '0 : (hold_q > HOLD_LAST ? hold_q : hold_q + 1'b1);
    dir_d  = long_d ? DIR_RESET : fsm_dir;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end
  assign long_pulse = long_q;
`else
  assign dir_d      = fsm_dir;
  assign long_pulse = 1'b0;
`endif
  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign dir           = dir_q;
endmodule

// File: tb/tb_button_dir_ctrl.sv
// tb_button_dir_ctrl: directed stimulus queues expected pulse events; a negedge monitor pops and checks them
module tb_button_dir_ctrl;
  localparam logic [2:0] K_PRESS = 3'b001, K_REL = 3'b010, K_LONG = 3'b100;
  typedef struct {
    logic [2:0] kind;
    int         cyc;
    logic       level;
    logic       dir;
    string      name;
  } ev_t;
  logic clk, rst_n, btn_in;
  logic btn_level, press_pulse, release_pulse, dir, long_pulse;
  ev_t exp_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [2:0] prev_p = 3'b000;
  button_dir_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DIR_RESET(1'b1),
    .LONG_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .dir(dir),
    .long_pulse(long_pulse)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic [2:0] p;
    ev_t e;
    p = {long_pulse, release_pulse, press_pulse};
    if (p != 3'b000) begin
      checks++;
      if (prev_p != 3'b000) begin
        errors++;
        $display("FAIL back_to_back: pulses=%b at edge %0d after pulses=%b, required a quiet cycle between", p, cyc, prev_p);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: pulses=%b at edge %0d level=%b dir=%b, required no pulse", p, cyc, btn_level, dir);
      end else begin
        e = exp_q.pop_front();
        if (p !== e.kind || cyc != e.cyc || btn_level !== e.level || dir !== e.dir) begin
          errors++;
          $display("FAIL %s: pulses=%b edge=%0d level=%b dir=%b, required pulses=%b edge=%0d level=%b dir=%b",
                   e.name, p, cyc, btn_level, dir, e.kind, e.cyc, e.level, e.dir);
        end
      end
    end
    prev_p = p;
  end
  task automatic expect_ev(input logic [2:0] k, input int c, input logic l, input logic d, input string n);
    ev_t e;
    e.kind  = k;
    e.cyc   = c;
    e.level = l;
    e.dir   = d;
    e.name  = n;
    exp_q.push_back(e);
  endtask
  task automatic drive(input logic v, input int n);
    btn_in = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask
  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_level", btn_level, 1'b0);
    check("reset_dir", dir, 1'b1);
    expect_ev(K_PRESS, cyc + 6, 1'b1, 1'b0, "clean_press");
    drive(1'b1, 10);
    check("held_level", btn_level, 1'b1);
    expect_ev(K_REL, cyc + 6, 1'b0, 1'b0, "clean_release");
    drive(1'b0, 10);
    do_reset();
    drive(1'b1, 3);
    drive(1'b0, 1);
    drive(1'b1, 3);
    drive(1'b0, 10);
    check("bounce_level", btn_level, 1'b0);
    check("bounce_dir", dir, 1'b1);
    do_reset();
    expect_ev(K_PRESS, cyc + 6, 1'b1, 1'b0, "press_a");
    drive(1'b1, 10);
    expect_ev(K_REL, cyc + 6, 1'b0, 1'b0, "release_a");
    drive(1'b0, 10);
    expect_ev(K_PRESS, cyc + 6, 1'b1, 1'b1, "press_b");
    drive(1'b1, 10);
    expect_ev(K_REL, cyc + 6, 1'b0, 1'b1, "release_b");
    drive(1'b0, 10);
    do_reset();
    btn_in = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_ev(K_PRESS, cyc + 6, 1'b1, 1'b0, "press_after_midreset");
    repeat (9) @(negedge clk);
    check("midreset_dir", dir, 1'b0);
    expect_ev(K_REL, cyc + 6, 1'b0, 1'b0, "release_after_midreset");
    drive(1'b0, 10);
    do_reset();
    expect_ev(K_PRESS, cyc + 6, 1'b1, 1'b0, "long_hold_press");
`ifdef LONG_PRESS_EN
    expect_ev(K_LONG, cyc + 26, 1'b1, 1'b1, "long_pulse");
    drive(1'b1, 40);
    expect_ev(K_REL, cyc + 6, 1'b0, 1'b1, "long_hold_release");
    drive(1'b0, 10);
    check("long_hold_dir", dir, 1'b1);
`else
    drive(1'b1, 40);
    expect_ev(K_REL, cyc + 6, 1'b0, 1'b0, "long_hold_release");
    drive(1'b0, 10);
    check("long_hold_dir", dir, 1'b0);
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d expected events never seen, first is %s", exp_q.size(), exp_q[0].name);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
